wgt_bank_ring: RTL and testbench

//  N-bank ring-buffered weight SRAM: generalises ping/pong weight storage to NBANKS banks.
//  DMA fills banks in order and commits them; the systolic array consumes them in order and releases them.

---
 rtl/wgt_bank_ring.sv | 87 ++++++++
 tb/tb_wgt_bank_ring.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/wgt_bank_ring.sv
// wgt_bank_ring: N-bank ring-buffered weight SRAM with per-bank fill/commit/consume/release tracking.
module wgt_bank_ring #(
  parameter int TN = 14,
  parameter int ADDR_WIDTH = 7,
  parameter int NBANKS = 4,
  localparam int BW = NBANKS > 1 ? $clog2(NBANKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [TN*8-1:0]       wr_data,
  input  logic [TN-1:0]         wr_strb,
  input  logic                  wr_commit,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_release,
  output logic                  rd_ready,
  output logic [ADDR_WIDTH:0]   rd_len,
  output logic [TN*8-1:0]       rd_data,
  output logic                  rd_valid,
  output logic                  rd_oob,
  output logic [BW:0]           banks_ready,
  output logic [1:0]            err
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  typedef enum logic [1:0] {EMPTY, FILLING, READY} bank_st_t;
  bank_st_t st [NBANKS];
  bank_st_t st_d [NBANKS];
  logic [TN*8-1:0] mem [NBANKS][DEPTH];
  logic [ADDR_WIDTH:0] len [NBANKS];
  logic [ADDR_WIDTH:0] hw, hw_d, wr_row;
  logic [BW-1:0] wr_ptr, rd_ptr;
  logic wr_ok, cm_ok, rel_ok, rd_ok, oob;
  function automatic logic [BW-1:0] inc(input logic [BW-1:0] p);
    return p == BW'(NBANKS - 1) ? '0 : p + BW'(1);
  endfunction
  assign wr_ready = st[wr_ptr] != READY;
  assign rd_ready = st[rd_ptr] == READY;
  assign wr_ok = wr_we & wr_ready;
  assign cm_ok = wr_commit & wr_ready;
  assign rel_ok = rd_release & rd_ready;
  assign rd_ok = rd_en & rd_ready;
  assign wr_row = {1'b0, wr_addr} + (ADDR_WIDTH + 1)'(1);
  // a write landing in the commit cycle still counts toward the committed length
  assign hw_d = wr_ok && wr_row > hw ? wr_row : hw;
  assign oob = {1'b0, rd_addr} >= len[rd_ptr];
  assign rd_len = rd_ready ? len[rd_ptr] : '0;
  always_comb begin
    st_d = st;
    if (wr_ok && st[wr_ptr] == EMPTY) st_d[wr_ptr] = FILLING;
    if (cm_ok) st_d[wr_ptr] = READY;
    if (rel_ok) st_d[rd_ptr] = EMPTY;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NBANKS; b++) begin
        st[b] <= EMPTY;
        len[b] <= '0;
      end
      hw <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      banks_ready <= '0;
      rd_valid <= 1'b0;
      rd_oob <= 1'b0;
      rd_data <= '0;
      err <= '0;
    end else begin
      st <= st_d;
      hw <= cm_ok ? '0 : hw_d;
      if (cm_ok) len[wr_ptr] <= hw_d;
      if (rel_ok) len[rd_ptr] <= '0;
      wr_ptr <= cm_ok ? inc(wr_ptr) : wr_ptr;
      rd_ptr <= rel_ok ? inc(rd_ptr) : rd_ptr;
      banks_ready <= banks_ready + (BW + 1)'(cm_ok) - (BW + 1)'(rel_ok);
      rd_valid <= rd_ok;
      rd_oob <= rd_ok & oob;
      if (rd_ok) rd_data <= oob ? '0 : mem[rd_ptr][rd_addr];
      err <= err | {(rd_en | rd_release) & ~rd_ready, (wr_we | wr_commit) & ~wr_ready};
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < TN; i++)
      if (!rst && wr_ok && wr_strb[i]) mem[wr_ptr][wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
endmodule

// File: tb/tb_wgt_bank_ring.sv
// tb_wgt_bank_ring: directed scenarios; read responses checked by a scoreboard monitor.
module tb_wgt_bank_ring;
  localparam int TN = 14;
  localparam int AW = 7;
  localparam int W = TN * 8;
  logic clk = 0;
  logic rst = 1;
  logic wr_we = 0, wr_commit = 0, rd_en = 0, rd_release = 0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [W-1:0] wr_data = '0;
  logic [TN-1:0] wr_strb = '0;
  logic wr_ready, rd_ready, rd_valid, rd_oob;
  logic [AW:0] rd_len;
  logic [W-1:0] rd_data;
  logic [2:0] banks_ready;
  logic [1:0] err;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic [W-1:0] d; logic oob;} exp_t;
  exp_t q[$];

  wgt_bank_ring #(.TN(TN), .ADDR_WIDTH(AW), .NBANKS(4)) dut (
    .clk(clk), .rst(rst), .wr_we(wr_we), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .wr_commit(wr_commit), .wr_ready(wr_ready), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_release(rd_release), .rd_ready(rd_ready), .rd_len(rd_len),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_oob(rd_oob), .banks_ready(banks_ready),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [7:0] b);
    return {TN{b}};
  endfunction

  always @(negedge clk)
    if (!rst && rd_valid) begin
      if (q.size() == 0) chk("unexpected_rd_valid", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("rd_data", rd_data, e.d);
        chk("rd_oob", rd_oob, e.oob);
      end
    end

  task automatic step();
    @(posedge clk);
    #1;
    wr_we = 0; wr_commit = 0; rd_en = 0; rd_release = 0; wr_strb = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [TN-1:0] s);
    wr_we = 1; wr_addr = a; wr_data = d; wr_strb = s;
    step();
  endtask

  task automatic commit();
    wr_commit = 1;
    step();
  endtask

  task automatic rel();
    rd_release = 1;
    step();
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [W-1:0] d, input logic o);
    rd_en = 1; rd_addr = a;
    q.push_back('{d, o});
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    step(); step();
    chk("rst_banks_ready", banks_ready, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_rd_len", rd_len, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_err", err, 0);
    rst = 0;
    step();
    // T1
    for (int r = 0; r < 4; r++) wr(AW'(r), rep(8'(8'h11 * (r + 1))), '1);
    chk("t1_rd_ready_pre", rd_ready, 0);
    commit();
    chk("t1_banks_ready", banks_ready, 1);
    chk("t1_rd_len", rd_len, 4);
    chk("t1_rd_ready", rd_ready, 1);
    rd(2, rep(8'h33), 0);
    step();
    chk("t1_hold_valid", rd_valid, 0);
    chk("t1_hold_data", rd_data, rep(8'h33));
    // T2: bank1
    wr(5, rep(8'hFF), '1);
    wr(5, '0, 14'h0001);
    commit();
    chk("t2_banks_ready", banks_ready, 2);
    rel();
    chk("t2_banks_ready_rel", banks_ready, 1);
    chk("t2_rd_len", rd_len, 6);
    rd(5, {{13{8'hFF}}, 8'h00}, 0);
    // T4 oob on bank1 (len 6)
    rd(7, '0, 1);
    rd(6, '0, 1);
    // T3: fill banks 2,3,0
    commit(); commit(); commit();
    chk("t3_banks_ready", banks_ready, 4);
    chk("t3_wr_ready", wr_ready, 0);
    chk("t3_err_pre", err, 0);
    wr(9, rep(8'h5A), '1);
    chk("t3_err", err, 2'b01);
    chk("t3_banks_ready_drop", banks_ready, 4);
    rel();
    chk("t3_wr_ready_rel", wr_ready, 1);
    chk("t3_banks_ready_rel", banks_ready, 3);
    // T5
    rel();
    chk("t5_banks_ready_pre", banks_ready, 2);
    wr_we = 1; wr_addr = 2; wr_data = rep(8'hAA); wr_strb = '1;
    wr_commit = 1; rd_release = 1;
    step();
    chk("t5_banks_ready_same", banks_ready, 2);
    chk("t5_rd_len_wrap", rd_len, 0);
    rd(0, '0, 1);
    rel();
    chk("t5_banks_ready_1", banks_ready, 1);
    chk("t5_rd_len_commit_write", rd_len, 3);
    rd_release = 1;
    rd(2, rep(8'hAA), 0);
    chk("t5_banks_ready_0", banks_ready, 0);
    chk("t5_rd_ready", rd_ready, 0);
    // T4 empty ring read
    rd_en = 1; rd_addr = 0;
    step();
    step();
    chk("t4_empty_valid", rd_valid, 0);
    chk("t4_err", err, 2'b11);
    // T6
    wr(0, rep(8'h77), '1);
    rst = 1;
    wr_we = 1; wr_addr = 3; wr_data = rep(8'h99); wr_strb = '1;
    step();
    rst = 0;
    chk("t6_banks_ready", banks_ready, 0);
    chk("t6_rd_valid", rd_valid, 0);
    chk("t6_rd_data", rd_data, 0);
    chk("t6_rd_oob", rd_oob, 0);
    chk("t6_err", err, 0);
    chk("t6_rd_ready", rd_ready, 0);
    chk("t6_wr_ready", wr_ready, 1);
    commit();
    chk("t6_banks_ready_commit", banks_ready, 1);
    chk("t6_rd_len", rd_len, 0);
    chk("t6_rd_ready_commit", rd_ready, 1);
    rd(0, '0, 1);
    step(); step();
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
